// File: rtl/shift_register_n.sv
// shift_register_n: WIDTH-bit register with synchronous reset, parallel load
// and left/right shift or rotate. A shift counter pulses done one cycle after
// every WIDTH-th shift, so a full word can be serialised or deserialised.
// sout presents the bit that leaves on the next shift in the current direction.

module shift_register_n #(
   parameter int unsigned      WIDTH  = 8,
   parameter logic [WIDTH-1:0] INI    = '0,
   parameter bit               ROTATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             done
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             done_q;
   logic             done_d;

   // One shift/rotate step; dir=0 moves toward the MSB, dir=1 toward the LSB.
   // In rotate mode the displaced bit re-enters at the opposite end.
   function automatic logic [WIDTH-1:0] shift_word(
      input logic [WIDTH-1:0] cur,
      input logic             to_lsb,
      input logic             ser_in
   );
      logic             ins;
      logic [WIDTH-1:0] res;
      case (to_lsb)
         1'b0: begin
            ins = ROTATE ? cur[WIDTH-1] : ser_in;
            res = {cur[WIDTH-2:0], ins};
         end
         1'b1: begin
            ins = ROTATE ? cur[0] : ser_in;
            res = {ins, cur[WIDTH-1:1]};
         end
         default: begin
            ins = 1'b0;
            res = cur;
         end
      endcase
      return res;
   endfunction

   // Next-state for data, shift counter and done pulse (load beats shift).
   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (load) begin
         q_d   = d;
         cnt_d = '0;
      end else if (shift) begin
         q_d = shift_word(q_q, dir, sin);
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         q_d   = q_q;
         cnt_d = cnt_q;
      end
   end

   // State registers; synchronous reset abandons any word in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= INI;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q    = q_q;
   assign done = done_q;
   assign sout = dir ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_n.sv
// Directed-vector bench for shift_register_n: one shift instance (ROTATE=0)
// and one rotate instance (ROTATE=1) share the same stimulus.

module tb_shift_register_n;

   logic       clk;
   logic       rst;
   logic [7:0] d;
   logic       load;
   logic       shift;
   logic       dir;
   logic       sin;

   logic [7:0] q_s;
   logic       sout_s;
   logic       done_s;
   logic [7:0] q_r;
   logic       sout_r;
   logic       done_r;

   int vectors;
   int miscompares;

   shift_register_n #(.WIDTH(8), .INI(8'hA5), .ROTATE(1'b0)) u_shf (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .load  (load),
      .shift (shift),
      .dir   (dir),
      .sin   (sin),
      .q     (q_s),
      .sout  (sout_s),
      .done  (done_s)
   );

   shift_register_n #(.WIDTH(8), .INI(8'hA5), .ROTATE(1'b1)) u_rot (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .load  (load),
      .shift (shift),
      .dir   (dir),
      .sin   (sin),
      .q     (q_r),
      .sout  (sout_r),
      .done  (done_r)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst   = 1'b1;
      d     = 8'h00;
      load  = 1'b0;
      shift = 1'b0;
      dir   = 1'b0;
      sin   = 1'b0;

      // Reset for two cycles, then idle.
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_vec("reset_q_shf", 32'(q_s), 32'h0000_00A5);
      chk_vec("reset_q_rot", 32'(q_r), 32'h0000_00A5);
      chk_vec("reset_done", 32'(done_s), 32'h0);
      chk_vec("reset_sout_l", 32'(sout_s), 32'h1);

      // Parallel load.
      d = 8'h3C; load = 1'b1;
      step();
      load = 1'b0;
      chk_vec("load_q", 32'(q_s), 32'h0000_003C);
      chk_vec("load_sout_l", 32'(sout_s), 32'h0);
      dir = 1'b1;
      #1;
      chk_vec("load_sout_r", 32'(sout_s), 32'h0);
      dir = 1'b0;

      // Serialise 8'h81 to the left with sin=0.
      d = 8'h81; load = 1'b1;
      step();
      load = 1'b0; shift = 1'b1; sin = 1'b0; dir = 1'b0;
      exp_q = 8'h81;
      for (int i = 0; i < 8; i++) begin
         chk_vec($sformatf("ser_sout%0d", i), 32'(sout_s), 32'(exp_q[7]));
         step();
         exp_q = {exp_q[6:0], 1'b0};
         chk_vec($sformatf("ser_done%0d", i), 32'(done_s), (i == 7) ? 32'h1 : 32'h0);
      end
      shift = 1'b0;
      chk_vec("ser_q", 32'(q_s), 32'h0);
      step();
      chk_vec("ser_done_drop", 32'(done_s), 32'h0);

      // Rotate right on the rotate instance.
      d = 8'h01; load = 1'b1;
      step();
      load = 1'b0; shift = 1'b1; dir = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk_vec("rot3_q", 32'(q_r), 32'h0000_0020);
      chk_vec("rot3_done", 32'(done_r), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_vec($sformatf("rot_done%0d", i + 4), 32'(done_r), (i == 4) ? 32'h1 : 32'h0);
      end
      chk_vec("rot8_q", 32'(q_r), 32'h0000_0001);
      shift = 1'b0;
      step();
      chk_vec("rot_done_drop", 32'(done_r), 32'h0);

      // Load and shift together: load wins, counter restarts.
      d = 8'hF0; load = 1'b1; shift = 1'b1; dir = 1'b0;
      step();
      load = 1'b0;
      chk_vec("ldsh_q", 32'(q_s), 32'h0000_00F0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_vec($sformatf("ldsh_done%0d", i), 32'(done_s), (i == 7) ? 32'h1 : 32'h0);
      end
      shift = 1'b0;

      // Reset with load: reset wins.
      rst = 1'b1; load = 1'b1; d = 8'h12;
      step();
      rst = 1'b0; load = 1'b0;
      chk_vec("rstld_q", 32'(q_s), 32'h0000_00A5);

      // Reset after 4 shifts abandons the word.
      d = 8'h81; load = 1'b1;
      step();
      load = 1'b0; shift = 1'b1;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_vec("midrst_q", 32'(q_s), 32'h0000_00A5);
      chk_vec("midrst_done", 32'(done_s), 32'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_vec($sformatf("midrst_done%0d", i), 32'(done_s), (i == 7) ? 32'h1 : 32'h0);
      end
      shift = 1'b0;

      // Continuous shifting of ones: done every 8 shifts.
      d = 8'h00; load = 1'b1;
      step();
      load = 1'b0; shift = 1'b1; sin = 1'b1; dir = 1'b0;
      exp_q = 8'h00;
      for (int i = 0; i < 24; i++) begin
         step();
         exp_q = {exp_q[6:0], 1'b1};
         chk_vec($sformatf("cont_q%0d", i), 32'(q_s), 32'(exp_q));
         chk_vec($sformatf("cont_done%0d", i), 32'(done_s), ((i % 8) == 7) ? 32'h1 : 32'h0);
      end
      shift = 1'b0;
      step();
      chk_vec("cont_done_end", 32'(done_s), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
